// File: rtl/logic_accum_pkg.sv
// Shared types for the multi-operand logic accumulator: operation codes and FSM states.
package logic_accum_pkg;

   typedef enum logic [1:0] {
      OP_AND  = 2'b00,
      OP_OR   = 2'b01,
      OP_XOR  = 2'b10,
      OP_NAND = 2'b11
   } op_t;

   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,
      ST_ACC  = 2'b01,
      ST_DONE = 2'b10
   } state_t;

endpackage

// File: rtl/logic_accum_if.sv
// Operand stream in, folded result out; both sides are valid/ready.
// A transfer happens on a rising clk edge where valid and ready are both high;
// valid may not depend on ready, and payload is held stable while valid waits for ready.
interface logic_accum_if #(
   parameter int WIDTH   = 32,
   parameter int MAX_OPS = 16
);
   localparam int CW = $clog2(MAX_OPS + 1);

   logic [1:0]       op;
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] in_data;
   logic             in_last;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] out_data;
   logic             out_zero;
   logic [CW-1:0]    out_count;
   logic             out_ovf;

   modport slave (
      input  op, in_valid, in_data, in_last, out_ready,
      output in_ready, out_valid, out_data, out_zero, out_count, out_ovf
   );

   modport master (
      output op, in_valid, in_data, in_last, out_ready,
      input  in_ready, out_valid, out_data, out_zero, out_count, out_ovf
   );

endinterface

// File: rtl/logic_op2.sv
// Two-input bitwise operator used for one fold step.
// NAND folds as AND; the top applies the final inversion.
module logic_op2
   import logic_accum_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  op_t              op,
   output logic [WIDTH-1:0] y
);

   always_comb begin
      y = a & b;
      case (op)
         OP_AND:  y = a & b;
         OP_OR:   y = a | b;
         OP_XOR:  y = a ^ b;
         OP_NAND: y = a & b;
         default: y = a & b;
      endcase
   end

endmodule

// File: rtl/logic_accum.sv
// Folds a packet of operand beats with one bitwise op and presents the result
// with zero flag, saturating beat count and overflow flag until it is taken.
module logic_accum
   import logic_accum_pkg::*;
#(
   parameter int WIDTH   = 32,
   parameter int MAX_OPS = 16
) (
   input  logic           clk,
   input  logic           rst,
   logic_accum_if.slave   bus,
   output state_t         state_dbg
);

   localparam int CW = $clog2(MAX_OPS + 1);

   state_t           state, state_nxt;
   logic [WIDTH-1:0] acc;
   logic [WIDTH-1:0] fold_y;
   logic [WIDTH-1:0] result;
   op_t              op_q;
   logic [CW-1:0]    count;
   logic             ovf;
   logic             accept;

   assign accept = bus.in_valid & bus.in_ready;

   logic_op2 #(.WIDTH(WIDTH)) u_op2 (
      .a  (acc),
      .b  (bus.in_data),
      .op (op_q),
      .y  (fold_y)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= ST_IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE: if (accept) state_nxt = bus.in_last ? ST_DONE : ST_ACC;
         ST_ACC:  if (accept && bus.in_last) state_nxt = ST_DONE;
         ST_DONE: if (bus.out_ready) state_nxt = ST_IDLE;
         default: state_nxt = ST_IDLE;
      endcase
   end

   always_comb begin
      bus.in_ready  = (state != ST_DONE);
      bus.out_valid = (state == ST_DONE);
   end

   // The first beat loads acc and latches op; later beats fold with the latched op.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         acc   <= '0;
         op_q  <= OP_AND;
         count <= '0;
         ovf   <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (accept) begin
                  acc   <= bus.in_data;
                  op_q  <= op_t'(bus.op);
                  count <= CW'(1);
                  ovf   <= 1'b0;
               end
            end
            ST_ACC: begin
               if (accept) begin
                  acc <= fold_y;
                  if (count == CW'(MAX_OPS)) ovf   <= 1'b1;
                  else                       count <= count + CW'(1);
               end
            end
            ST_DONE: begin
               if (bus.out_ready) begin
                  count <= '0;
                  ovf   <= 1'b0;
               end
            end
            default: ;
         endcase
      end
   end

   assign result        = (op_q == OP_NAND) ? ~acc : acc;
   assign bus.out_data  = result;
   assign bus.out_zero  = (result == '0);
   assign bus.out_count = count;
   assign bus.out_ovf   = ovf;
   assign state_dbg     = state;

endmodule

// File: tb/tb_logic_accum.sv
// Bench for logic_accum (WIDTH=8, MAX_OPS=4): directed packets from the datasheet
// scenarios plus random packets, checked against a fold model and expected queue.
module tb_logic_accum;
   import logic_accum_pkg::*;

   localparam int WIDTH   = 8;
   localparam int MAX_OPS = 4;

   logic   clk;
   logic   rst;
   state_t state_dbg;

   logic_accum_if #(.WIDTH(WIDTH), .MAX_OPS(MAX_OPS)) bus ();

   logic_accum #(.WIDTH(WIDTH), .MAX_OPS(MAX_OPS)) dut (
      .clk       (clk),
      .rst       (rst),
      .bus       (bus),
      .state_dbg (state_dbg)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int vectors     = 0;
   int miscompares = 0;

   logic [WIDTH-1:0] exp_q[$];
   logic [WIDTH-1:0] beats[$];

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      if (obs !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   // Reference: plain left-to-right fold of the packet, NAND = inverted AND-fold.
   function automatic logic [WIDTH-1:0] ref_fold(input logic [1:0] o);
      logic [WIDTH-1:0] r;
      r = beats[0];
      for (int i = 1; i < beats.size(); i++) begin
         if (o == 2'b01)      r = r | beats[i];
         else if (o == 2'b10) r = r ^ beats[i];
         else                 r = r & beats[i];
      end
      if (o == 2'b11) r = ~r;
      return r;
   endfunction

   task automatic run_packet(input logic [1:0] pkt_op, input int hold, input bit gaps);
      int               n;
      int               exp_cnt;
      logic [WIDTH-1:0] d;
      n       = beats.size();
      exp_cnt = (n > MAX_OPS) ? MAX_OPS : n;
      exp_q.push_back(ref_fold(pkt_op));
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         if (gaps && $urandom_range(0, 2) == 0) begin
            bus.in_valid  = 1'b0;
            bus.op        = 2'($urandom);
            bus.out_ready = 1'($urandom);
            bus.in_data   = 8'($urandom);
            @(negedge clk);
            bus.out_ready = 1'b0;
         end
         bus.in_valid = 1'b1;
         bus.in_data  = beats[i];
         bus.in_last  = (i == n - 1);
         bus.op       = (i == 0) ? pkt_op : 2'($urandom);
         check("in_ready_beat", 32'(bus.in_ready), 32'd1);
         check("out_valid_busy", 32'(bus.out_valid), 32'd0);
         @(posedge clk);
      end
      @(negedge clk);
      bus.in_valid = 1'b0;
      bus.in_last  = 1'b0;
      d = exp_q.pop_front();
      check("out_valid", 32'(bus.out_valid), 32'd1);
      check("in_ready_done", 32'(bus.in_ready), 32'd0);
      check("state_done", 32'(state_dbg), 32'(ST_DONE));
      check("out_data", 32'(bus.out_data), 32'(d));
      check("out_zero", 32'(bus.out_zero), 32'(d == '0));
      check("out_count", 32'(bus.out_count), 32'(exp_cnt));
      check("out_ovf", 32'(bus.out_ovf), 32'(n > MAX_OPS));
      for (int h = 0; h < hold; h++) begin
         bus.in_valid = 1'b1;
         bus.in_data  = 8'($urandom);
         bus.in_last  = 1'($urandom);
         @(negedge clk);
         check("hold_valid", 32'(bus.out_valid), 32'd1);
         check("hold_data", 32'(bus.out_data), 32'(d));
         check("hold_in_ready", 32'(bus.in_ready), 32'd0);
         check("hold_count", 32'(bus.out_count), 32'(exp_cnt));
      end
      bus.in_valid  = 1'b0;
      bus.in_last   = 1'b0;
      bus.out_ready = 1'b1;
      @(negedge clk);
      bus.out_ready = 1'b0;
      check("drain_valid", 32'(bus.out_valid), 32'd0);
      check("drain_in_ready", 32'(bus.in_ready), 32'd1);
      check("drain_count", 32'(bus.out_count), 32'd0);
      check("drain_ovf", 32'(bus.out_ovf), 32'd0);
      check("drain_state", 32'(state_dbg), 32'(ST_IDLE));
   endtask

   task automatic check_reset_values(input string tag);
      check({tag, "_in_ready"}, 32'(bus.in_ready), 32'd1);
      check({tag, "_out_valid"}, 32'(bus.out_valid), 32'd0);
      check({tag, "_out_data"}, 32'(bus.out_data), 32'd0);
      check({tag, "_out_zero"}, 32'(bus.out_zero), 32'd1);
      check({tag, "_out_count"}, 32'(bus.out_count), 32'd0);
      check({tag, "_out_ovf"}, 32'(bus.out_ovf), 32'd0);
      check({tag, "_state"}, 32'(state_dbg), 32'(ST_IDLE));
   endtask

   initial begin
      rst           = 1'b1;
      bus.op        = 2'b00;
      bus.in_valid  = 1'b0;
      bus.in_data   = '0;
      bus.in_last   = 1'b0;
      bus.out_ready = 1'b0;
      repeat (2) @(negedge clk);
      check_reset_values("reset");
      rst = 1'b0;

      // AND F0,3C,FF -> 30
      beats = '{8'hF0, 8'h3C, 8'hFF};
      run_packet(2'b00, 0, 1'b0);
      // XOR 0F,0F -> 00, zero flag
      beats = '{8'h0F, 8'h0F};
      run_packet(2'b10, 0, 1'b0);
      // single-beat NAND A5 -> 5A, goes IDLE->DONE directly
      beats = '{8'hA5};
      run_packet(2'b11, 0, 1'b0);
      // backpressure: result held five cycles while junk beats are offered
      beats = '{8'h81, 8'h18, 8'h42};
      run_packet(2'b01, 5, 1'b0);
      // OR over six beats with MAX_OPS=4 -> 3F, count saturates, ovf set
      beats = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20};
      run_packet(2'b01, 0, 1'b0);

      // reset in the middle of an accumulating packet
      for (int i = 0; i < 2; i++) begin
         @(negedge clk);
         bus.in_valid = 1'b1;
         bus.in_data  = 8'($urandom);
         bus.in_last  = 1'b0;
         bus.op       = 2'b01;
         @(posedge clk);
      end
      @(negedge clk);
      bus.in_valid = 1'b0;
      check("pre_reset_state", 32'(state_dbg), 32'(ST_ACC));
      rst = 1'b1;
      #1;
      check_reset_values("midrst");
      @(negedge clk);
      rst = 1'b0;
      beats = '{8'hCE, 8'h7B};
      run_packet(2'b00, 0, 1'b0);

      // random packets, lengths straddling the saturation point
      for (int p = 0; p < 60; p++) begin
         int n;
         n = $urandom_range(1, 7);
         beats.delete();
         for (int i = 0; i < n; i++) beats.push_back(8'($urandom));
         run_packet(2'($urandom), $urandom_range(0, 3), 1'b1);
      end

      check("exp_q_empty", 32'(exp_q.size()), 32'd0);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
